// File: rtl/imem_pkg.sv
// Shared constants, state/owner encodings and the address range helper for the
// instruction-memory arbiter.
package imem_pkg;

  localparam int WIDTH        = 32;
  localparam int DEPTH        = 256;
  localparam int AW           = $clog2(DEPTH);
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [0:0] {ARB = 1'b0, LOCK = 1'b1} state_e;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_LOAD  = 1'b1;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  // Byte address -> word index compared against the memory depth.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled for port connection.
interface imem_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 8
);
  logic             fetch_req;
  logic [31:0]      fetch_addr;
  logic             fetch_gnt;
  logic             fetch_rvalid;
  logic [WIDTH-1:0] fetch_rdata;

  logic             load_req;
  logic             load_we;
  logic             load_lock;
  logic [31:0]      load_addr;
  logic [WIDTH-1:0] load_wdata;
  logic             load_gnt;
  logic             load_rvalid;
  logic [WIDTH-1:0] load_rdata;

  logic             addr_err;

  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    input  load_req, load_we, load_lock, load_addr, load_wdata,
    output load_gnt, load_rvalid, load_rdata,
    output addr_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    output load_req, load_we, load_lock, load_addr, load_wdata,
    input  load_gnt, load_rvalid, load_rdata,
    input  addr_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter_starve_counter.sv
// Saturating count of fetch grants taken while the loader is waiting.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != CW'(LIMIT)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sat = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter for a single-ported synchronous-read instruction memory,
// with starvation relief for the loader and an exclusive lock mode.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int WIDTH        = imem_pkg::WIDTH,
  parameter int DEPTH        = imem_pkg::DEPTH,
  parameter int STARVE_LIMIT = imem_pkg::STARVE_LIMIT
) (
  input logic          clk,
  input logic          rst,
  imem_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [0:0]  state_q, state_d;
  logic        vld_q, vld_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;

  logic        starve_sat;
  logic        fetch_gnt, load_gnt, any_gnt;
  logic        locked;
  logic [31:0] req_addr;
  logic        req_ok;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (fetch_gnt && bus.load_req),
    .clr (load_gnt || !bus.load_req),
    .sat (starve_sat)
  );

  // A lock only holds while load_lock stays high; the release cycle arbitrates normally.
  assign locked = (state_q == ST_LOCK) && bus.load_lock;

  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (!rst) begin
      if (locked)
        load_gnt = bus.load_req;
      else if (bus.fetch_req && !(bus.load_req && starve_sat))
        fetch_gnt = 1'b1;
      else
        load_gnt = bus.load_req;
    end
  end

  assign any_gnt  = fetch_gnt || load_gnt;
  assign req_addr = load_gnt ? bus.load_addr : bus.fetch_addr;
  assign req_ok   = addr_in_range(req_addr, DEPTH);

  always_comb begin
    state_d = ST_ARB;
    if (locked || (load_gnt && bus.load_lock))
      state_d = ST_LOCK;
  end

  // Response bookkeeping: writes never produce rvalid, but an out-of-range write still flags.
  always_comb begin
    vld_d   = fetch_gnt || (load_gnt && !bus.load_we);
    owner_d = owner_q;
    if (vld_d)
      owner_d = load_gnt ? OWN_LOAD : OWN_FETCH;
    err_d   = any_gnt && !req_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      vld_q   <= 1'b0;
      owner_q <= OWN_FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign bus.fetch_gnt = fetch_gnt;
  assign bus.load_gnt  = load_gnt;

  assign bus.mem_en    = any_gnt && req_ok;
  assign bus.mem_we    = any_gnt && req_ok && load_gnt && bus.load_we;
  assign bus.mem_addr  = req_addr[AW+1:2];
  assign bus.mem_wdata = bus.load_wdata;

  // Responses are masked while rst is high so an in-flight read never surfaces.
  assign bus.fetch_rvalid = !rst && vld_q && (owner_q == OWN_FETCH);
  assign bus.load_rvalid  = !rst && vld_q && (owner_q == OWN_LOAD);
  assign bus.addr_err     = !rst && err_q;
  assign bus.fetch_rdata  = (bus.fetch_rvalid && !err_q) ? bus.mem_rdata : '0;
  assign bus.load_rdata   = (bus.load_rvalid && !err_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model of arbitration and memory contents.
module tb_imem_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  imem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External synchronous-read memory, preloaded with word i at index i.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_q;
  bit               mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [WIDTH-1:0] shadow [DEPTH];
  bit          m_locked;
  int          m_waits;          // fetch grants taken since the loader was last served
  bit          p_vld, p_load, p_err;
  logic [31:0] p_data;

  // Output samples of the most recent cycle
  logic s_fg, s_lg, s_frv, s_lrv, s_err, s_en;
  logic [31:0] s_fd, s_ld;

  task automatic step();
    int          win;            // 0 none, 1 fetch, 2 load
    logic [31:0] a;
    int unsigned idx;
    bit          ok;
    logic        e_fg, e_lg, e_frv, e_lrv, e_err, e_en, e_we;
    logic [31:0] e_fd, e_ld;
    @(negedge clk);
    s_fg = bus.fetch_gnt;  s_lg = bus.load_gnt;
    s_frv = bus.fetch_rvalid; s_lrv = bus.load_rvalid;
    s_fd = bus.fetch_rdata; s_ld = bus.load_rdata;
    s_err = bus.addr_err;  s_en = bus.mem_en;

    win = 0; a = 0; idx = 0; ok = 0;
    e_frv = 0; e_lrv = 0; e_fd = 0; e_ld = 0; e_err = 0;
    if (!rst) begin
      e_frv = p_vld && !p_load;
      e_lrv = p_vld && p_load;
      e_fd  = e_frv ? p_data : 32'h0;
      e_ld  = e_lrv ? p_data : 32'h0;
      e_err = p_err;
      if (m_locked && bus.load_lock)             win = bus.load_req ? 2 : 0;
      else if (bus.fetch_req && !(bus.load_req && m_waits >= LIMIT)) win = 1;
      else if (bus.load_req)                     win = 2;
    end
    if (win != 0) begin
      a   = (win == 2) ? bus.load_addr : bus.fetch_addr;
      idx = a / 4;
      ok  = idx < DEPTH;
    end
    e_fg = (win == 1);
    e_lg = (win == 2);
    e_en = (win != 0) && ok;
    e_we = e_en && e_lg && bus.load_we;

    chk("fetch_gnt", 32'(s_fg), 32'(e_fg));
    chk("load_gnt", 32'(s_lg), 32'(e_lg));
    chk("mem_en", 32'(s_en), 32'(e_en));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("fetch_rvalid", 32'(s_frv), 32'(e_frv));
    chk("load_rvalid", 32'(s_lrv), 32'(e_lrv));
    chk("fetch_rdata", s_fd, e_fd);
    chk("load_rdata", s_ld, e_ld);
    chk("addr_err", 32'(s_err), 32'(e_err));
    if (e_en) chk("mem_addr", 32'(bus.mem_addr), idx);
    if (e_we) chk("mem_wdata", bus.mem_wdata, bus.load_wdata);

    if (rst) begin
      m_locked = 0; m_waits = 0; p_vld = 0; p_load = 0; p_err = 0; p_data = 0;
    end else begin
      if (win == 2 || !bus.load_req) m_waits = 0;
      else if (win == 1 && m_waits < LIMIT) m_waits++;
      m_locked = bus.load_lock && (m_locked || win == 2);
      p_vld  = (win == 1) || (win == 2 && !bus.load_we);
      p_load = (win == 2);
      p_err  = (win != 0) && !ok;
      p_data = (p_vld && ok) ? shadow[idx] : 32'h0;
      if (e_we) shadow[idx] = bus.load_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_req = 0; bus.load_req = 0; bus.load_we = 0; bus.load_lock = 0;
  endtask

  logic [9:0] pat;
  logic       fg_seen;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = WIDTH'(i);
    m_locked = 0; m_waits = 0; p_vld = 0; p_load = 0; p_err = 0; p_data = 0;
    idle();
    bus.fetch_addr = 0; bus.load_addr = 0; bus.load_wdata = 0;
    rst = 1;
    step(); step();
    chk("rst_fetch_gnt", 32'(s_fg), 0);
    chk("rst_mem_en", 32'(s_en), 0);
    rst = 0;

    // Fetch-only stream
    bus.fetch_req = 1;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_addr = 32'(i * 4);
      step();
      chk("fo_gnt", 32'(s_fg), 1);
      if (i > 0) chk("fo_rdata", s_fd, 32'(i - 1));
    end
    bus.fetch_req = 0;
    step();
    chk("fo_rdata_last", s_fd, 32'd2);

    // Both requesting continuously
    bus.fetch_req = 1; bus.fetch_addr = 32'h10;
    bus.load_req = 1; bus.load_we = 0; bus.load_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      step();
      pat[9 - i] = s_fg;
    end
    chk("contention_pattern", 32'(pat), 32'(10'b1111011110));
    idle();
    step();

    // Locked image write, fetch held off
    bus.load_req = 1; bus.load_we = 1; bus.load_lock = 1; bus.load_wdata = 32'hDEADBEEF;
    fg_seen = 0;
    for (int i = 0; i < 8; i++) begin
      bus.load_addr = 32'(i * 4);
      step();
      fg_seen = fg_seen | s_fg;
      bus.fetch_req = 1; bus.fetch_addr = 32'h0;
    end
    chk("lock_no_fetch", 32'(fg_seen), 0);
    bus.load_req = 0; bus.load_lock = 0; bus.load_we = 0;
    step();
    chk("unlock_fetch_gnt", 32'(s_fg), 1);
    bus.fetch_req = 0;
    step();
    chk("unlock_rdata", s_fd, 32'hDEADBEEF);

    // Out-of-range fetch
    bus.fetch_req = 1; bus.fetch_addr = 32'h400;
    step();
    chk("oor_gnt", 32'(s_fg), 1);
    chk("oor_mem_en", 32'(s_en), 0);
    bus.fetch_req = 0;
    step();
    chk("oor_rvalid", 32'(s_frv), 1);
    chk("oor_rdata", s_fd, 0);
    chk("oor_err", 32'(s_err), 1);

    // Load write then read-back
    bus.load_req = 1; bus.load_we = 1; bus.load_addr = 32'h8; bus.load_wdata = 32'h12345678;
    step();
    bus.load_we = 0;
    step();
    bus.load_req = 0;
    step();
    chk("rb_rvalid", 32'(s_lrv), 1);
    chk("rb_rdata", s_ld, 32'h12345678);
    chk("rb_fetch_rvalid", 32'(s_frv), 0);

    // Reset with a fetch in flight
    bus.fetch_req = 1; bus.fetch_addr = 32'hC;
    step();
    rst = 1; bus.fetch_req = 0;
    step();
    chk("rstmid_rvalid_n1", 32'(s_frv), 0);
    rst = 0;
    step();
    chk("rstmid_rvalid_n2", 32'(s_frv), 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.fetch_req = $urandom_range(0, 3) != 0;
      bus.load_req  = $urandom_range(0, 2) != 0;
      bus.load_we   = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) bus.load_lock = ~bus.load_lock;
      bus.fetch_addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom)};
      bus.load_addr  = 32'($urandom_range(0, DEPTH + 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.fetch_addr = $urandom;
      if ($urandom_range(0, 29) == 0) bus.fetch_addr = 32'($urandom_range(DEPTH, DEPTH + 8) * 4);
      bus.load_wdata = $urandom;
      step();
    end
    rst = 0; idle();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter and sequencer for the single-ported, word-addressed instruction memory. It shares the memory between the CPU fetch port and a program-load port (UART/debug loader) and presents a synchronous-read memory interface. Fetch has priority, and a starvation counter guarantees the loader periodic access. A lock mode gives the loader exclusive ownership while a program image is being written.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 256, memory depth in words; AW = $clog2(DEPTH)
- STARVE_LIMIT, 4, consecutive fetch grants allowed while load_req is pending before load wins one cycle (≥1)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request (read only)
- fetch_addr  in  32  byte address; word index = fetch_addr[31:2]
- fetch_gnt  out  1  request accepted this cycle (combinational)
- fetch_rvalid  out  1  fetch_rdata valid (one cycle after grant)
- fetch_rdata  out  WIDTH  instruction word
- load_req  in  1  loader request
- load_we  in  1  1 = write, 0 = read-back
- load_lock  in  1  loader requests exclusive ownership
- load_addr  in  32  byte address
- load_wdata  in  WIDTH  write data
- load_gnt  out  1  loader request accepted this cycle (combinational)
- load_rvalid  out  1  read-back data valid
- load_rdata  out  WIDTH  read-back word
- addr_err  out  1  pulses with rvalid when the granted address was out of range
- mem_en, mem_we  out  1 each  memory enable / write enable
- mem_addr  out  AW  word index
- mem_wdata  out  WIDTH  write data
- mem_rdata  in  WIDTH  memory read data, valid one cycle after mem_en && !mem_we

## Operation
- State machine {ARB, LOCK}; reset → ARB.
- ARB:
  - Grant fetch if fetch_req, unless load_req && starve_cnt == STARVE_LIMIT, in which case grant load.
  - Otherwise grant load if load_req.
  - starve_cnt increments on a fetch grant while load_req is high, saturating at STARVE_LIMIT. It clears on any load grant or whenever load_req is low.
- ARB → LOCK: on a load grant with load_lock = 1.
- LOCK: fetch_gnt = 0. load_req is granted every cycle. LOCK → ARB on the first cycle with load_lock = 0, in which fetch arbitration applies normally.
- At most one grant per cycle. A granted request drives mem_en = 1 and mem_addr = addr[AW+1:2]. For a load write, mem_we = 1 and mem_wdata = load_wdata.
- Response routing: a 1-bit owner register and a valid register capture each granted read. The next cycle raises exactly one rvalid, with rdata = mem_rdata. Writes produce no rvalid.
- Out of range (addr[31:2] ≥ DEPTH): the request is still granted, mem_en = 0, and the next cycle gives rvalid = 1, rdata = 0 and addr_err = 1. A write is dropped, and addr_err still pulses on that next cycle.
- addr[1:0] is ignored, so misaligned addresses are truncated.
- Unselected rdata outputs hold 0.

## Timing
- Grant latency is 0 cycles (combinational from req/state/cnt). Read latency is 1 cycle from grant to rvalid.
- Throughput is one access per cycle, with back-to-back grants and no bubbles on requester switch.
- Reset values: all gnt/rvalid/addr_err = 0; rdata = 0; mem_en = mem_we = 0; state = ARB; starve_cnt = 0; owner = fetch.
- Reset asserted with a read in flight: the pending rvalid is suppressed and no response is issued after reset.
- load_lock rising while the loader is not granted has no effect until the loader's next grant.
- Simultaneous requests in ARB with starve_cnt < STARVE_LIMIT: fetch wins.

## Structure
- Package imem_pkg holds DEPTH, WIDTH, AW, STARVE_LIMIT defaults, the state enum {ARB, LOCK}, the owner encoding (OWN_FETCH = 0, OWN_LOAD = 1) and NOP_WORD = 32'h00000013.
- Single top module. The memory array is external and attached via mem_*.
- One natural sub-module: starve_counter (saturating counter with clear).

## Test plan
- Fetch only: fetch_req held with addresses 0, 4, 8 → gnt every cycle; rvalid each following cycle with words 0, 1, 2.
- Contention with STARVE_LIMIT = 4, both requesting continuously → grant pattern F F F F L F F F F L.
- Lock load: load_lock = 1 with writes of 32'hDEADBEEF to addresses 0x0 … 0x1C while fetch_req is held → fetch_gnt = 0 throughout. After load_lock drops, fetch at 0x0 returns 32'hDEADBEEF.
- Out of range: fetch_addr = 0x400 with DEPTH = 256 → gnt, mem_en = 0, next cycle rvalid = 1, rdata = 0, addr_err = 1.
- Reset mid-read: fetch granted at cycle N, rst = 1 at N+1 → fetch_rvalid = 0 at N+1 and afterwards, state = ARB.
- Load read-back: load_we = 0 at address 0x8 after a write of 32'h12345678 → load_rvalid next cycle, load_rdata = 32'h12345678, fetch_rvalid = 0.
